// File: rtl/multi_interval_timer_pkg.sv
// Shared definitions for the multi-channel interval timer.
// Covers register offsets, CONTROL bit positions and the STATUS word layout.
package timer_pkg;

  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD   = 3'd2,
    REG_COMPARE  = 3'd3,
    REG_SNAPSHOT = 3'd4
  } reg_offset_e;

  localparam int CTRL_W      = 16;
  localparam int CTRL_ITO    = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_START  = 2;
  localparam int CTRL_STOP   = 3;
  localparam int CTRL_PWM_EN = 4;
  localparam int CTRL_PS_LSB = 8;
  localparam int CTRL_PS_MSB = 15;

  // STATUS reads back as {30'b0, run, to}
  typedef struct packed {
    logic run;
    logic to;
  } status_t;

endpackage

// File: rtl/multi_interval_timer_if.sv
// Memory-mapped slave bus of the interval timer.
// The master drives address and the write strobe; the slave returns registered readdata.
interface multi_interval_timer_if #(
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/multi_interval_timer_channel.sv
// One timer channel: register file, prescaled down-counter, timeout flag and PWM compare.
// The top level handles address decode; this block only sees its own write strobe and offset.
module timer_channel
  import timer_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int unsigned RST_PERIOD = 49999999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_off,
  input  logic [31:0]       wr_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  compare,
  output logic [CNT_W-1:0]  snapshot,
  output status_t           status,
  output logic              irq,
  output logic              pwm
);

  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RST_PERIOD);

  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  period_q, compare_q, snapshot_q, count_q;
  logic [7:0]        presc_q, prescale;
  logic              run_q, to_q, zero_d_q;
  logic              wr_status, wr_ctrl, wr_period, wr_compare, wr_snap;
  logic              at_zero, tick;

  assign wr_status  = wr_en && (wr_off == REG_STATUS);
  assign wr_ctrl    = wr_en && (wr_off == REG_CONTROL);
  assign wr_period  = wr_en && (wr_off == REG_PERIOD);
  assign wr_compare = wr_en && (wr_off == REG_COMPARE);
  assign wr_snap    = wr_en && (wr_off == REG_SNAPSHOT);

  assign prescale = ctrl_q[CTRL_PS_MSB:CTRL_PS_LSB];
  assign at_zero  = (count_q == '0);
  assign tick     = run_q && (presc_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      period_q   <= RST_VAL;
      compare_q  <= '0;
      snapshot_q <= '0;
    end else begin
      if (wr_ctrl)    ctrl_q     <= {wr_data[15:8], 3'b000, wr_data[4:0]};
      if (wr_period)  period_q   <= wr_data[CNT_W-1:0];
      if (wr_compare) compare_q  <= wr_data[CNT_W-1:0];
      if (wr_snap)    snapshot_q <= count_q;
    end
  end

  // A PERIOD write restarts the channel from scratch in a stopped state.
  // Otherwise START beats STOP, and STOP beats the one-shot auto-stop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= RST_VAL;
      presc_q <= '0;
      run_q   <= 1'b0;
    end else if (wr_period) begin
      count_q <= wr_data[CNT_W-1:0];
      presc_q <= '0;
      run_q   <= 1'b0;
    end else begin
      if (tick) begin
        presc_q <= prescale;
        count_q <= at_zero ? period_q : count_q - CNT_W'(1);
      end else if (run_q) begin
        presc_q <= presc_q - 8'd1;
      end
      if (wr_ctrl && wr_data[CTRL_START]) begin
        run_q <= 1'b1;
      end else if (wr_ctrl && wr_data[CTRL_STOP]) begin
        run_q <= 1'b0;
      end else if (tick && at_zero && !ctrl_q[CTRL_CONT]) begin
        run_q <= 1'b0;
      end
    end
  end

  // zero_d_q resets high so leaving reset never looks like a fresh arrival at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q     <= 1'b0;
      zero_d_q <= 1'b1;
    end else begin
      zero_d_q <= at_zero;
      if (wr_status) begin
        to_q <= 1'b0;
      end else if (at_zero && !zero_d_q) begin
        to_q <= 1'b1;
      end
    end
  end

  assign ctrl       = ctrl_q;
  assign period     = period_q;
  assign compare    = compare_q;
  assign snapshot   = snapshot_q;
  assign status.run = run_q;
  assign status.to  = to_q;
  assign irq        = to_q && ctrl_q[CTRL_ITO];
  assign pwm        = ctrl_q[CTRL_PWM_EN] && run_q && (count_q < compare_q);

endmodule

// File: rtl/multi_interval_timer.sv
// Multi-channel interval timer with a memory-mapped register bus.
// Decodes {channel, offset} addresses, muxes the registered read data and merges interrupts.
module multi_interval_timer
  import timer_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter int unsigned RST_PERIOD = 49999999,
  localparam int         ADDR_W     = $clog2(NUM_CH) + 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  multi_interval_timer_if.slave bus,
  output logic                  irq,
  output logic [NUM_CH-1:0]     irq_vec,
  output logic [NUM_CH-1:0]     pwm_out
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [2:0]                  offset;
  logic [IDX_W-1:0]            ch_idx;
  logic                        ch_valid;
  logic                        wr_strobe;
  logic [NUM_CH-1:0][31:0]     ch_rd;
  logic [31:0]                 rd_next;

  assign offset = bus.address[2:0];

  if (NUM_CH > 1) begin : g_idx
    assign ch_idx = bus.address[ADDR_W-1:3];
  end else begin : g_idx_single
    assign ch_idx = '0;
  end

  // Non-power-of-two channel counts leave holes in the index space that must stay inert.
  assign ch_valid  = int'(ch_idx) < NUM_CH;
  assign wr_strobe = bus.chipselect && !bus.write_n && ch_valid;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CTRL_W-1:0] ctrl;
    logic [CNT_W-1:0]  period, compare, snapshot;
    status_t           status;
    logic [31:0]       rd_word;

    timer_channel #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (RST_PERIOD)
    ) u_channel (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr_strobe && (ch_idx == IDX_W'(i))),
      .wr_off   (offset),
      .wr_data  (bus.writedata),
      .ctrl     (ctrl),
      .period   (period),
      .compare  (compare),
      .snapshot (snapshot),
      .status   (status),
      .irq      (irq_vec[i]),
      .pwm      (pwm_out[i])
    );

    always_comb begin
      rd_word = '0;
      case (offset)
        REG_STATUS:   rd_word = 32'(status);
        REG_CONTROL:  rd_word = 32'(ctrl);
        REG_PERIOD:   rd_word = 32'(period);
        REG_COMPARE:  rd_word = 32'(compare);
        REG_SNAPSHOT: rd_word = 32'(snapshot);
        default:      rd_word = '0;
      endcase
    end

    assign ch_rd[i] = rd_word;
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_valid && (ch_idx == IDX_W'(i))) begin
        rd_next = ch_rd[i];
      end
    end
  end

  // Read data tracks the address every cycle, whether or not a read is intended.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

  assign irq = |irq_vec;

endmodule

// File: doc/multi_interval_timer.md
MULTI_INTERVAL_TIMER -- requirements
Module: multi_interval_timer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent timer channels, range 1..8.
REQ-002 Parameter CNT_W, default 32: counter, period and compare width, range 8..32.
REQ-003 Parameter RST_PERIOD, default 49999999: period reset value of every channel, truncated to CNT_W.
REQ-004 Derived ADDR_W = clog2(NUM_CH)+3; address = {channel index, register offset[2:0]}.
REQ-005 clk  input  1  system clock.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 address  input  ADDR_W  word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  1  OR of irq_vec.
REQ-013 irq_vec  output  NUM_CH  per-channel interrupt: TO AND ITO.
REQ-014 pwm_out  output  NUM_CH  per-channel compare output.

Function
REQ-015 Register offsets per channel SHALL be: 0 STATUS, 1 CONTROL, 2 PERIOD, 3 COMPARE, 4 SNAPSHOT, 5..7 reserved (read 0, write ignored).
REQ-016 STATUS SHALL read {30'b0, RUN, TO}; any write to STATUS SHALL clear TO.
REQ-017 CONTROL SHALL hold ITO[0], CONT[1], PWM_EN[4], PRESCALE[15:8]; bit 2 START and bit 3 STOP SHALL act as write strobes and also be stored, as in CONTROL[3:0].
REQ-018 A CONTROL write with START=1 SHALL set RUN on the next clock; STOP=1 SHALL clear RUN; START and STOP in the same write: START wins.
REQ-019 While RUN=1, a prescale counter SHALL count down from PRESCALE; the main counter SHALL decrement once per prescale wrap, i.e. once every PRESCALE+1 clocks.
REQ-020 When the counter is 0 and a tick occurs: reload with PERIOD; if CONT=0, RUN SHALL clear on that same clock.
REQ-021 A PERIOD write SHALL, on the following clock, reload the counter from the new PERIOD, reset the prescaler, and clear RUN.
REQ-022 TO SHALL set on the first clock the counter equals 0, rising edge only; a STATUS write in that same cycle wins, and TO stays 0.
REQ-023 pwm_out[n] SHALL be 1 iff PWM_EN=1, RUN=1 and counter < COMPARE; otherwise 0.
REQ-024 Any write to SNAPSHOT SHALL copy the live counter into SNAPSHOT on the next clock; reads return the captured value.
REQ-025 readdata SHALL update one clock after the address is presented, regardless of read intent; widths below 32 are zero-extended.
REQ-026 Writes to a channel index >= NUM_CH SHALL be ignored, and reads from it SHALL return 0.
REQ-027 Channels SHALL be fully independent; simultaneous timeouts on several channels SHALL each set their own TO.

Reset
REQ-028 On reset_n=0, asynchronously: counter=RST_PERIOD, PERIOD=RST_PERIOD, COMPARE=0, CONTROL=0, RUN=0, TO=0, SNAPSHOT=0, prescaler=0, readdata=0; therefore irq=0, irq_vec=0, pwm_out=0.
REQ-029 Reset mid-count SHALL abandon the count; no timeout or irq SHALL be produced by the deassertion itself.

Structure
REQ-030 Package timer_pkg SHALL hold register offsets, CONTROL bit positions and the STATUS layout.
REQ-031 A sub-module timer_channel, parametrised by CNT_W and RST_PERIOD, SHALL implement one channel and SHALL be generated NUM_CH times; the top level holds address decode, the read mux and irq reduction.

Verification
REQ-032 Ch0: PERIOD=9, PRESCALE=0, CONT=0, ITO=1, then START -> TO=1 and irq=1 exactly 10 clocks after counting starts, and RUN=0.
REQ-033 Ch1: PERIOD=3, PRESCALE=2, CONT=1, START -> a TO rising event every 12 clocks; a STATUS write clears irq_vec[1] until the next event.
REQ-034 Ch2: PERIOD=99, COMPARE=25, PWM_EN=1, CONT=1 -> pwm_out[2] high for 25 of every 100 clocks.
REQ-035 A PERIOD write while running -> RUN=0 and counter=new PERIOD two clocks after the write; a CONTROL write with START=1 and STOP=1 -> RUN=1.
REQ-036 A STATUS write coincident with the zero-reach cycle -> TO stays 0; assert reset_n mid-count -> all outputs 0 immediately, and the counter reads back RST_PERIOD via a SNAPSHOT write.
REQ-037 NUM_CH=3: a write to channel index 3 -> no channel state changes, and reads from it return 0.
